// File: rtl/division_pkg.sv
// Shared definitions for the repeated-subtraction divider: FSM state encoding and default width.
package division_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/division_datapath.sv
// Divider datapath: dividend/remainder register A, divisor register B, quotient register P,
// subtractor, incrementer and unsigned comparator. Port a exists only with DIVISION_REMAINDER_EN.
module division_datapath import division_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             lda,
  input  logic             ldb,
  input  logic             clrp,
  input  logic             incp,
  input  logic             satp,
  input  logic             selin,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic             b_zero,
`ifdef DIVISION_REMAINDER_EN
  output logic [WIDTH-1:0] a,
`endif
  output logic [WIDTH-1:0] p
);

`ifndef DIVISION_REMAINDER_EN
  logic [WIDTH-1:0] a;
`endif
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;

  // Only evaluated into A when A >= B, so the difference never underflows.
  assign diff = a - b;

  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      p <= '0;
    end else begin
      if (lda) a <= selin ? data_in : diff;
      if (ldb) b <= data_in;
      if (clrp)      p <= '0;
      else if (satp) p <= '1;
      else if (incp) p <= p + 1'b1;
    end
  end

  assign lt     = (a < b);
  assign gt     = (a > b);
  assign eq     = (a == b);
  assign b_zero = (b == '0);

endmodule

// File: rtl/division_controller.sv
// Top of the divider: two-process FSM that sequences the datapath strobes.
// Optional macro DIVISION_REMAINDER_EN exposes the remainder on port rem.
module division_controller import division_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] p,
`ifdef DIVISION_REMAINDER_EN
  output logic [WIDTH-1:0] rem,
`endif
  output logic             done
);

  state_t state, next_state;
  logic lda, ldb, clrp, incp, satp, selin;
  logic lt, gt, eq, b_zero;

  division_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .lda     (lda),
    .ldb     (ldb),
    .clrp    (clrp),
    .incp    (incp),
    .satp    (satp),
    .selin   (selin),
    .lt      (lt),
    .gt      (gt),
    .eq      (eq),
    .b_zero  (b_zero),
`ifdef DIVISION_REMAINDER_EN
    .a       (rem),
`endif
    .p       (p)
  );

  // done is registered from the next state so it is high exactly while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (next_state == DONE);
    end
  end

  always_comb begin
    next_state = state;
    lda   = 1'b0;
    ldb   = 1'b0;
    clrp  = 1'b0;
    incp  = 1'b0;
    satp  = 1'b0;
    selin = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          ldb        = 1'b1;
          clrp       = 1'b1;
          next_state = LOAD_A;
        end
      end
      LOAD_A: begin
        lda        = 1'b1;
        selin      = 1'b1;
        next_state = CALC;
      end
      CALC: begin
        // Zero divisor saturates the quotient instead of looping forever.
        if (b_zero) begin
          satp       = 1'b1;
          next_state = DONE;
        end else if (gt || eq) begin
          lda  = 1'b1;
          incp = 1'b1;
        end else if (lt) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (!start) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_division_controller.sv
// Self-checking bench for division_controller: directed corner cases plus random operands
// checked against plain integer division.
module tb_division_controller;

  localparam int W = 5;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] p;
  logic         done;
`ifdef DIVISION_REMAINDER_EN
  logic [W-1:0] rem;
`endif

  int checks = 0;
  int errors = 0;

  division_controller #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .p       (p),
`ifdef DIVISION_REMAINDER_EN
    .rem     (rem),
`endif
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Runs one division and compares quotient, remainder and latency with integer arithmetic.
  task automatic applyStimulus(input int divisor, input int dividend, input bit hold_start);
    int exp_q, exp_r, exp_lat, edges;
    bit seen;
    if (divisor == 0) begin
      exp_q = MAXV; exp_r = dividend; exp_lat = 3;
    end else begin
      exp_q = dividend / divisor; exp_r = dividend % divisor; exp_lat = exp_q + 3;
    end
    @(negedge clk);
    start   = 1'b1;
    data_in = divisor[W-1:0];
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    checkOutput("done_low_after_start", {31'd0, done}, 32'd0);
    if (!hold_start) start = 1'b0;
    data_in = dividend[W-1:0];
    seen = 1'b0;
    while (!seen && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      data_in = W'($urandom);
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", {31'd0, seen}, 32'd1);
    checkOutput("latency", edges, exp_lat);
    checkOutput("quotient", {27'd0, p}, exp_q);
`ifdef DIVISION_REMAINDER_EN
    checkOutput("remainder", {27'd0, rem}, exp_r);
`endif
    if (hold_start) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("done_held", {31'd0, done}, 32'd1);
      checkOutput("quotient_held", {27'd0, p}, exp_q);
      start = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("done_cleared", {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_p", {27'd0, p}, 32'd0);
    rst = 1'b0;

    // Idle with start low must not disturb anything.
    data_in = 5'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_done", {31'd0, done}, 32'd0);
    checkOutput("idle_p", {27'd0, p}, 32'd0);

    applyStimulus(2, 15, 1'b0);
    applyStimulus(15, 2, 1'b0);
    applyStimulus(1, 31, 1'b0);
    applyStimulus(4, 12, 1'b0);
    applyStimulus(0, 9, 1'b0);
    applyStimulus(3, 3, 1'b1);

    // Reset mid-CALC discards the partial quotient.
    @(negedge clk);
    start   = 1'b1;
    data_in = 5'd2;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    data_in = 5'd15;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("midcalc_p_nonzero", {31'd0, (p != 0)}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midcalc_reset_p", {27'd0, p}, 32'd0);
    checkOutput("midcalc_reset_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("after_reset_idle", {31'd0, done}, 32'd0);
    applyStimulus(2, 15, 1'b0);

    for (int i = 0; i < 25; i++) begin
      applyStimulus(int'($urandom_range(0, MAXV)), int'($urandom_range(0, MAXV)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
